multi_channel_light_fader: RTL and testbench

- Brightness controller for NUM_CH independent LED channels, all sharing one set of user-step inputs.
- inc/dec pulses (from the rotary-encoder decoder) adjust the target brightness of the currently selected channel; a channel-select pulse rotates the selection.
- In fade mode, each channel's output level ramps toward its target at a programmable rate instead of jumping.
- Each channel drives one PWM output through a shared free-running PWM counter; the block sits between the encoder decoder and the board LEDs.

---
 rtl/light_pkg.sv | 26 ++
 rtl/light_fade_channel.sv | 68 ++++++
 rtl/multi_channel_light_fader.sv | 80 ++++++++
 tb/tb_multi_channel_light_fader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared constants and width helpers
// for the multi-channel LED fader.
package light_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_STEP     = 5;
    localparam int DEF_FADE_DIV = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/light_fade_channel.sv
// One LED channel: saturating target,
// level ramp and PWM compare.
module light_fade_channel
    import light_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int STEP = DEF_STEP
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         fade_en_i,
    input  logic         fade_tick_i,
    input  logic [W-1:0] pwm_cnt_i,
    output logic         pwm_o,
    output logic         mismatch_o
);

    localparam logic [W-1:0] MAX    = '1;
    localparam logic [W-1:0] STEP_V = W'(STEP);
    localparam logic [W-1:0] HEAD   = MAX - STEP_V;

    logic [W-1:0] target_q;
    logic [W-1:0] target_d;
    logic [W-1:0] level_q;
    logic [W-1:0] level_d;

    // Saturating target step; inc and dec together cancel.
    always_comb begin
        target_d = target_q;
        if (inc_i && !dec_i) begin
            target_d = (target_q > HEAD) ? MAX : target_q + STEP_V;
        end else if (dec_i && !inc_i) begin
            target_d = (target_q < STEP_V) ? '0 : target_q - STEP_V;
        end
    end

    // Level snaps to target, or moves by one on each fade tick.
    always_comb begin
        level_d = level_q;
        if (!fade_en_i) begin
            level_d = target_q;
        end else if (fade_tick_i) begin
            if (level_q < target_q) begin
                level_d = level_q + W'(1);
            end else if (level_q > target_q) begin
                level_d = level_q - W'(1);
            end
        end
    end

    // Channel state and registered PWM output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            target_q <= '0;
            level_q  <= '0;
            pwm_o    <= 1'b0;
        end else begin
            target_q <= target_d;
            level_q  <= level_d;
            pwm_o    <= (level_q > pwm_cnt_i);
        end
    end

    assign mismatch_o = (level_q != target_q);

endmodule

// File: rtl/multi_channel_light_fader.sv
// Shared selection, fade prescaler and
// PWM counter driving NUM_CH fade channels.
module multi_channel_light_fader
    import light_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int PWM_VALUE_SIZE = DEF_W,
    parameter int BRIGHTNESS_INC = DEF_STEP,
    parameter int FADE_DIV       = DEF_FADE_DIV
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      inc_i,
    input  logic                      dec_i,
    input  logic                      next_ch_i,
    input  logic                      fade_en_i,
    output logic [NUM_CH-1:0]         leds_o,
    output logic [ch_w(NUM_CH)-1:0]   sel_ch_o,
    output logic                      busy_o
);

    localparam int W     = PWM_VALUE_SIZE;
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int PRE_W = ch_w(FADE_DIV);

    localparam logic [W-1:0]     MAX     = '1;
    localparam logic [W-1:0]     CNT_TOP = MAX - W'(1);
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(FADE_DIV - 1);
    localparam logic [CH_W-1:0]  SEL_TOP = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]   sel_q;
    logic [PRE_W-1:0]  pre_q;
    logic [W-1:0]      pwm_q;
    logic              fade_tick;
    logic [NUM_CH-1:0] mismatch;

    assign fade_tick = (pre_q == PRE_TOP);

    // Selection rotation, prescaler, PWM counter and busy flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q  <= '0;
            pre_q  <= '0;
            pwm_q  <= '0;
            busy_o <= 1'b0;
        end else begin
            if (next_ch_i) begin
                sel_q <= (sel_q == SEL_TOP) ? '0 : sel_q + CH_W'(1);
            end
            pre_q  <= fade_tick ? '0 : pre_q + PRE_W'(1);
            pwm_q  <= (pwm_q == CNT_TOP) ? '0 : pwm_q + W'(1);
            busy_o <= |mismatch;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_inc;
        logic ch_dec;
        assign ch_inc = inc_i && (sel_q == CH_W'(i));
        assign ch_dec = dec_i && (sel_q == CH_W'(i));

        light_fade_channel #(
            .W    (W),
            .STEP (BRIGHTNESS_INC)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .inc_i       (ch_inc),
            .dec_i       (ch_dec),
            .fade_en_i   (fade_en_i),
            .fade_tick_i (fade_tick),
            .pwm_cnt_i   (pwm_q),
            .pwm_o       (leds_o[i]),
            .mismatch_o  (mismatch[i])
        );
    end

    assign sel_ch_o = sel_q;

endmodule

// File: tb/tb_multi_channel_light_fader.sv
// Scoreboard bench for the multi-channel
// fader against a behavioural model.
module tb_multi_channel_light_fader;

    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int STEP = 5;
    localparam int FD   = 4;
    localparam int MAX  = 255;

    typedef struct packed {
        logic [NCH-1:0] leds;
        logic [1:0]     sel;
        logic           busy;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           inc;
    logic           dec;
    logic           nxt;
    logic           fade;
    logic [NCH-1:0] leds_o;
    logic [1:0]     sel_ch_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    int             tgt[NCH];
    int             lvl[NCH];
    int             pre;
    int             pwm;
    int             msel;
    logic [NCH-1:0] mleds;
    logic           mbusy;

    multi_channel_light_fader #(
        .NUM_CH         (NCH),
        .PWM_VALUE_SIZE (W),
        .BRIGHTNESS_INC (STEP),
        .FADE_DIV       (FD)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .inc_i     (inc),
        .dec_i     (dec),
        .next_ch_i (nxt),
        .fade_en_i (fade),
        .leds_o    (leds_o),
        .sel_ch_o  (sel_ch_o),
        .busy_o    (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            tgt[c] = 0;
            lvl[c] = 0;
        end
        pre   = 0;
        pwm   = 0;
        msel  = 0;
        mleds = '0;
        mbusy = 1'b0;
    endtask

    // One clock of the brightness rules, evaluated on old state.
    task automatic model_step(input bit i, input bit d,
                              input bit n, input bit f);
        int  ot[NCH];
        int  ol[NCH];
        bit  tick;
        ot    = tgt;
        ol    = lvl;
        tick  = (pre == FD - 1);
        mbusy = 1'b0;
        if (i && !d) begin
            tgt[msel] = (ot[msel] + STEP > MAX) ? MAX : ot[msel] + STEP;
        end else if (d && !i) begin
            tgt[msel] = (ot[msel] - STEP < 0) ? 0 : ot[msel] - STEP;
        end
        for (int c = 0; c < NCH; c++) begin
            mleds[c] = (ol[c] > pwm);
            if (ol[c] != ot[c]) mbusy = 1'b1;
            if (!f) begin
                lvl[c] = ot[c];
            end else if (tick) begin
                if (ol[c] < ot[c]) lvl[c] = ol[c] + 1;
                else if (ol[c] > ot[c]) lvl[c] = ol[c] - 1;
            end
        end
        pre = (pre + 1) % FD;
        pwm = (pwm + 1) % MAX;
        if (n) msel = (msel + 1) % NCH;
    endtask

    task automatic cyc(input bit i, input bit d, input bit n);
        exp_t e;
        inc = i;
        dec = d;
        nxt = n;
        @(posedge clk);
        model_step(i, d, n, fade);
        e.leds = mleds;
        e.sel  = 2'(msel);
        e.busy = mbusy;
        q.push_back(e);
        #1;
        inc = 1'b0;
        dec = 1'b0;
        nxt = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_leds", int'(leds_o), 0);
        check("rst_sel", int'(sel_ch_o), 0);
        check("rst_busy", int'(busy_o), 0);
        model_reset();
        q.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic duty(input int ch, input int exp);
        int hi;
        hi = 0;
        for (int k = 0; k < MAX; k++) begin
            cyc(0, 0, 0);
            if (leds_o[ch]) hi++;
        end
        check($sformatf("duty_ch%0d", ch), hi, exp);
    endtask

    task automatic wait_lvl(input int ch, input int v, input int budget);
        int k;
        k = 0;
        while (lvl[ch] != v && k < budget) begin
            cyc(0, 0, 0);
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy_o && k < budget) begin
            cyc(0, 0, 0);
            k++;
        end
        check("busy_clear", int'(busy_o), 0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output word.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("leds", int'(leds_o), int'(e.leds));
            check("sel", int'(sel_ch_o), int'(e.sel));
            check("busy", int'(busy_o), int'(e.busy));
        end
    end

    initial begin
        int r;
        rst_n = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        nxt   = 1'b0;
        fade  = 1'b0;
        model_reset();
        do_reset();
        idle(600);

        repeat (3) cyc(1, 0, 0);
        idle(2);
        duty(0, 15);

        repeat (53) cyc(1, 0, 0);
        idle(2);
        duty(0, 255);

        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 1);
        repeat (2) cyc(0, 1, 0);
        cyc(1, 0, 1);
        idle(2);
        duty(0, 250);
        duty(1, 0);

        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 63) == 0) fade = ~fade;
            if (r < 30)      cyc(1, 0, 0);
            else if (r < 50) cyc(0, 1, 0);
            else if (r < 58) cyc(0, 0, 1);
            else if (r < 62) cyc(1, 1, 0);
            else if (r < 64) cyc(1, 0, 1);
            else             cyc(0, 0, 0);
        end

        fade = 1'b0;
        do_reset();
        fade = 1'b1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        wait_lvl(2, 7, 200);
        cyc(0, 1, 0);
        wait_idle(200);
        duty(2, 5);

        cyc(1, 1, 0);
        idle(2);
        duty(2, 5);

        repeat (4) cyc(1, 0, 0);
        idle(10);
        do_reset();
        idle(60);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
